// File: rtl/vproc_cfg_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vproc_cfg_pkg / vproc_cfg_unit_if                                          |
// | vtype field encodings and the request/response bus of the config unit.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vproc_cfg_pkg;
  typedef enum logic [1:0] {
    VSEW_8       = 2'd0,
    VSEW_16      = 2'd1,
    VSEW_32      = 2'd2,
    VSEW_INVALID = 2'd3
  } cfg_vsew;

  // Fractional encodings follow vlmul: the low bits are minus log2 of the denominator.
  typedef enum logic [2:0] {
    LMUL_1       = 3'd0,
    LMUL_2       = 3'd1,
    LMUL_4       = 3'd2,
    LMUL_8       = 3'd3,
    LMUL_INVALID = 3'd4,
    LMUL_F8      = 3'd5,
    LMUL_F4      = 3'd6,
    LMUL_F2      = 3'd7
  } cfg_lmul;

  typedef struct packed {
    cfg_vsew    vsew;
    cfg_lmul    lmul;
    logic [1:0] agnostic;
    logic       vlmax;
    logic       keep_vl;
  } op_mode_cfg;
endpackage

interface vproc_cfg_unit_if #(
  parameter int ID_W = 4
);
  import vproc_cfg_pkg::*;

  logic            req_valid_i;
  logic            req_ready_o;
  op_mode_cfg      req_mode_i;
  logic [31:0]     req_avl_i;
  logic [ID_W-1:0] req_id_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [31:0]     rsp_vl_o;
  logic [ID_W-1:0] rsp_id_o;

  modport master (
    output req_valid_i, req_mode_i, req_avl_i, req_id_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_vl_o, rsp_id_o
  );

  modport slave (
    input  req_valid_i, req_mode_i, req_avl_i, req_id_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_vl_o, rsp_id_o
  );
endinterface
`default_nettype wire

// File: rtl/vproc_cfg_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vproc_cfg_unit                                                             |
// | vsetvl/vsetvli/vsetivli: computes VLMAX and vl, commits vtype/vl state.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vproc_cfg_unit
  import vproc_cfg_pkg::*;
#(
  parameter  int VREG_W = 128,
  parameter  int ID_W   = 4,
  localparam int VL_W   = $clog2(VREG_W) + 1
) (
  input  logic             clk_i,
  input  logic             async_rst_i,
  vproc_cfg_unit_if.slave  bus,
  output cfg_vsew          vsew_o,
  output cfg_lmul          lmul_o,
  output logic [1:0]       agnostic_o,
  output logic             vill_o,
  output logic [VL_W-1:0]  vl_o,
  output logic [3:0]       cfg_epoch_o
);

  localparam logic [31:0] C_BASE = 32'(VREG_W / 8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  op_mode_cfg      r_mode;
  logic [31:0]     r_avl;
  logic [ID_W-1:0] r_id;

  cfg_vsew         r_vsew;
  cfg_lmul         r_lmul;
  logic [1:0]      r_agnostic;
  logic            r_vill;
  logic [VL_W-1:0] r_vl;
  logic [3:0]      r_epoch;

  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_vl;
  logic [ID_W-1:0] r_rsp_id;

  logic            w_illegal;
  logic [2:0]      w_int_shift;
  logic [2:0]      w_frac_shift;
  logic [3:0]      w_rshift;
  logic [31:0]     w_vlmax;
  logic [31:0]     w_cur_vl;
  logic [31:0]     w_vl;

  always_comb begin
    w_illegal = 1'b0;
    case (r_mode.lmul)
      LMUL_INVALID, LMUL_F8: w_illegal = 1'b1;
      LMUL_F4:               w_illegal = (r_mode.vsew != VSEW_8);
      LMUL_F2:               w_illegal = (r_mode.vsew == VSEW_32);
      default:               w_illegal = 1'b0;
    endcase
    if ((r_mode.vsew == VSEW_INVALID) || (r_mode.keep_vl && r_vill)) begin
      w_illegal = 1'b1;
    end
  end

  // VLMAX = (VREG_W/8) * LMUL / (SEW/8); the vsew code is log2(SEW/8).
  assign w_int_shift  = r_mode.lmul[2] ? 3'd0 : {1'b0, r_mode.lmul[1:0]};
  assign w_frac_shift = r_mode.lmul[2] ? (3'd0 - 3'(r_mode.lmul)) : 3'd0;
  assign w_rshift     = {2'b00, r_mode.vsew} + {1'b0, w_frac_shift};
  assign w_vlmax      = (C_BASE << w_int_shift) >> w_rshift;
  assign w_cur_vl     = {{(32-VL_W){1'b0}}, r_vl};

  always_comb begin
    w_vl = '0;
    if (w_illegal) begin
      w_vl = '0;
    end else if (r_mode.keep_vl) begin
      w_vl = (w_cur_vl < w_vlmax) ? w_cur_vl : w_vlmax;
    end else if (r_mode.vlmax) begin
      w_vl = w_vlmax;
    end else begin
      w_vl = (r_avl < w_vlmax) ? r_avl : w_vlmax;
    end
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      r_state     <= ST_IDLE;
      r_mode      <= '0;
      r_avl       <= '0;
      r_id        <= '0;
      r_vsew      <= VSEW_8;
      r_lmul      <= LMUL_1;
      r_agnostic  <= 2'b00;
      r_vill      <= 1'b1;
      r_vl        <= '0;
      r_epoch     <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_vl    <= '0;
      r_rsp_id    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            r_mode      <= bus.req_mode_i;
            r_avl       <= bus.req_avl_i;
            r_id        <= bus.req_id_i;
            r_req_ready <= 1'b0;
            r_state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (w_illegal) begin
            r_vsew     <= VSEW_8;
            r_lmul     <= LMUL_1;
            r_agnostic <= 2'b00;
            r_vill     <= 1'b1;
          end else begin
            r_vsew     <= r_mode.vsew;
            r_lmul     <= r_mode.lmul;
            r_agnostic <= r_mode.agnostic;
            r_vill     <= 1'b0;
          end
          r_vl        <= w_vl[VL_W-1:0];
          r_epoch     <= r_epoch + 4'd1;
          r_rsp_vl    <= w_vl;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o = r_req_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_vl_o    = r_rsp_vl;
  assign bus.rsp_id_o    = r_rsp_id;
  assign vsew_o          = r_vsew;
  assign lmul_o          = r_lmul;
  assign agnostic_o      = r_agnostic;
  assign vill_o          = r_vill;
  assign vl_o            = r_vl;
  assign cfg_epoch_o     = r_epoch;

endmodule
`default_nettype wire

// File: doc/vproc_cfg_unit.md
# vproc_cfg_unit

Vector configuration unit for vsetvl/vsetvli/vsetivli. Accepts decoded configuration requests carrying `op_mode_cfg` fields plus an AVL. Computes VLMAX and the new vl, then commits the architectural vtype/vl state. Returns the new vl for the scalar rd writeback. It sits between the decoder (upstream) and the dispatcher and execution units (downstream), which read the committed vsew/lmul/vl.

## Interface
Parameters:
- `VREG_W`, 128: vector register width in bits; power of two, ≥ 64.
- `ID_W`, 4: request tag width.
- localparam `VL_W` = $clog2(VREG_W)+1: width of vl.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `async_rst_i`  in  1  reset; asynchronous, active-high.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when high together with valid.
- `req_mode_i`  in  `op_mode_cfg`  fields used: vsew, lmul, agnostic, vlmax, keep_vl.
- `req_avl_i`  in  32  application vector length (rs1 value or uimm).
- `req_id_i`  in  `ID_W`  tag, returned unchanged on the response.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_vl_o`  out  32  new vl, zero-extended, for rd.
- `rsp_id_o`  out  `ID_W`  tag of the request.
- `vsew_o`  out  `cfg_vsew`  committed SEW.
- `lmul_o`  out  `cfg_lmul`  committed LMUL.
- `agnostic_o`  out  2  committed tail/mask agnostic bits.
- `vill_o`  out  1  configuration illegal.
- `vl_o`  out  `VL_W`  committed vl.
- `cfg_epoch_o`  out  4  commit counter, wraps 15→0.

## Operation
FSM states: IDLE, CALC, RESP.
- IDLE: `req_ready_o`=1. On valid&ready, capture mode, AVL and id; go to CALC.
- CALC: compute the result and commit the architectural state; go to RESP.
- RESP: `rsp_valid_o`=1. On `rsp_ready_i`, go to IDLE. Otherwise hold; all response outputs stay stable.

Legality:
- Illegal if vsew=VSEW_INVALID or lmul=LMUL_INVALID.
- Illegal if lmul=LMUL_F8, for any SEW.
- Illegal if lmul=LMUL_F4 with SEW≠8.
- Illegal if lmul=LMUL_F2 with SEW=32.
- Illegal if keep_vl=1 while `vill_o`=1.

VLMAX computation:
- Integer LMUL (1, 2, 4, 8): VLMAX = VREG_W·LMUL/SEW.
- Fractional LMUL (1/2, 1/4): VLMAX = VREG_W/(SEW·denominator).
- Implemented as shifts only; no divider.

New vl, in priority order:
- keep_vl=1: vl = min(current `vl_o`, VLMAX).
- vlmax=1: vl = VLMAX.
- Otherwise: vl = min(AVL, VLMAX), compared at the full 32-bit AVL width.

Commit on a legal request:
- vsew, lmul and agnostic are taken from the request.
- vill=0, vl as computed.
- `rsp_vl_o` = vl.

Commit on an illegal request:
- vsew=VSEW_8, lmul=LMUL_1, agnostic=0.
- vill=1, vl=0, `rsp_vl_o`=0.

Every commit, legal or illegal, increments `cfg_epoch_o`.

## Timing
Reset values:
- FSM in IDLE; `req_ready_o`=1, `rsp_valid_o`=0.
- `rsp_vl_o`=0, `rsp_id_o`=0.
- `vsew_o`=VSEW_8, `lmul_o`=LMUL_1, `agnostic_o`=0.
- `vill_o`=1, `vl_o`=0, `cfg_epoch_o`=0.

Latency and throughput:
- Request accepted at edge T. State outputs and `cfg_epoch_o` update at edge T+1. `rsp_valid_o` rises after edge T+1, visible during cycle T+1.
- One request is in flight at a time. `req_ready_o`=0 in CALC and RESP.
- A new request can be accepted in the cycle after the response handshake. Maximum throughput is one request per 3 cycles.

Combinational paths:
- `req_ready_o` is a registered-state decode only.
- No combinational path from `rsp_ready_i` to `req_ready_o`, and none from the `req_*` inputs to any output.

Other rules:
- Architectural outputs change only at the CALC→RESP edge. Downstream may use `cfg_epoch_o` to detect stale configuration.
- Reset asserted in any state forces the reset values immediately. The in-flight request is dropped and no response is produced.
- `req_valid_i` asserted outside IDLE is ignored. The decoder must hold it until ready.

## Test plan
All scenarios use VREG_W=128.
- **Reset:** assert `async_rst_i` mid-RESP → `rsp_valid_o`=0, `vill_o`=1, `vl_o`=0, `cfg_epoch_o`=0, `req_ready_o`=1 without a clock edge.
- **Basic vsetvli, latency:** SEW32, LMUL_2, AVL=5, id=3 → VLMAX=8, `vl_o`=5, `rsp_vl_o`=5, `rsp_id_o`=3, `vill_o`=0, epoch=1, `rsp_valid_o` in cycle T+1.
- **AVL clamp and vlmax flag:** SEW8, LMUL_8, AVL=5000 → vl=128. SEW16, LMUL_F2, vlmax=1 → vl=4.
- **Illegal configurations:** LMUL_F8 with SEW8, or VSEW_INVALID → `vill_o`=1, vl=0, rsp_vl=0, vsew=VSEW_8, lmul=LMUL_1, epoch incremented. Then keep_vl=1 → stays illegal.
- **keep_vl clamp:** legal vl=5, then keep_vl=1 with SEW32, LMUL_1 (VLMAX=4) → vl=4, rsp_vl=4.
- **Backpressure and wrap:** hold `rsp_ready_i`=0 for 3 cycles → response stable, `req_ready_o`=0, a pending request is not accepted until the cycle after the handshake. Issue 16 back-to-back commits → epoch wraps to 0.
